// File: rtl/mult_seq_if.sv
// rtl/mult_seq_if.sv - start/busy/done multiplier handshake bundle
interface mult_seq_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   out;

    modport master (output start, output a, output b, input busy, input done, input out);
    modport slave  (input start, input a, input b, output busy, output done, output out);
endinterface

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - unsigned shift-add multiplier, one partial product per clock
module mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    mult_seq_if.slave  bus
);
    localparam int              PW   = 2 * WIDTH;
    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   a_reg_q, a_reg_d;
    logic [WIDTH-1:0] b_reg_q, b_reg_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   out_q, out_d;
    logic [PW-1:0]   acc_sum;

    // This iteration's accumulation, also what out captures on the final iteration.
    assign acc_sum = acc_q + (b_reg_q[0] ? a_reg_q : '0);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_reg_d = a_reg_q;
        b_reg_d = b_reg_q;
        count_d = count_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_reg_d = {{WIDTH{1'b0}}, bus.a};
                    b_reg_d = bus.b;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_sum;
                a_reg_d = a_reg_q << 1;
                b_reg_d = b_reg_q >> 1;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    out_d   = acc_sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_reg_q <= '0;
            b_reg_q <= '0;
            count_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_reg_q <= a_reg_d;
            b_reg_q <= b_reg_d;
            count_q <= count_d;
            out_q   <= out_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.out  = out_q;
endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - self-checking bench for mult_seq (WIDTH=16 and WIDTH=4)
module tb_mult_seq;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   done_cnt;

    mult_seq_if #(.WIDTH(16)) s16 ();
    mult_seq_if #(.WIDTH(4))  s4 ();

    mult_seq #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(s16.slave));
    mult_seq #(.WIDTH(4))  dut4  (.clk(clk), .reset(reset), .bus(s4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (s16.done) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // One full 16-bit operation: checks busy from E0, out stable during RUN,
    // done exactly 16 edges after E0, single-cycle pulse and held result.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
        logic [31:0] prev;
        int n;
        @(negedge clk);
        prev = s16.out;
        s16.start = 1'b1; s16.a = a; s16.b = b;
        @(posedge clk);
        @(negedge clk);
        s16.start = 1'b0; s16.a = $urandom; s16.b = $urandom;
        check("busy_after_accept", 32'(s16.busy), 32'd1);
        n = 0;
        while (!s16.done && n < 40) begin
            if (s16.out !== prev) check("out_stable_run", s16.out, prev);
            @(negedge clk);
            n++;
        end
        check("done_latency", 32'(n), 32'd16);
        check("product", s16.out, exp);
        @(negedge clk);
        check("done_one_cycle", {30'd0, s16.busy, s16.done}, 32'd0);
        check("out_held", s16.out, exp);
    endtask

    vec_t vecs[5];
    int   base;
    int   cyc;
    int   ndone;
    int   t1;
    int   n4;

    initial begin
        checks = 0; failures = 0; done_cnt = 0;
        vecs[0] = '{16'd3,      16'd5,      32'd15};
        vecs[1] = '{16'hFFFF,   16'hFFFF,   32'hFFFE0001};
        vecs[2] = '{16'd0,      16'h1234,   32'd0};
        vecs[3] = '{16'd10,     16'd10,     32'd100};
        vecs[4] = '{16'h8000,   16'd2,      32'h00010000};

        reset = 1'b1;
        s16.start = 1'b0; s16.a = '0; s16.b = '0;
        s4.start  = 1'b0; s4.a  = '0; s4.b  = '0;
        #1;
        check("reset_16", {s16.out[29:0], s16.busy, s16.done}, 32'd0);
        check("reset_4",  {22'd0, s4.out, s4.busy, s4.done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].exp);

        for (int i = 0; i < 20; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(ra, rb, 32'(ra) * 32'(rb));
        end

        // Start requests while busy are dropped.
        base = done_cnt;
        @(negedge clk);
        s16.start = 1'b1; s16.a = 16'd7; s16.b = 16'd9;
        @(posedge clk);
        @(negedge clk);
        s16.start = 1'b0;
        repeat (4) @(negedge clk);
        s16.start = 1'b1; s16.a = 16'd2; s16.b = 16'd2;
        @(negedge clk);
        s16.start = 1'b0;
        n4 = 0;
        while (!s16.done && n4 < 40) begin @(negedge clk); n4++; end
        check("busy_start_done_seen", 32'(s16.done), 32'd1);
        check("busy_start_product", s16.out, 32'd63);
        s16.start = 1'b1;
        @(negedge clk);
        s16.start = 1'b0;
        repeat (20) @(negedge clk);
        check("busy_start_idle", 32'(s16.busy), 32'd0);
        check("busy_start_one_done", 32'(done_cnt - base), 32'd1);
        check("busy_start_out_kept", s16.out, 32'd63);

        // Asynchronous reset mid-RUN.
        base = done_cnt;
        @(negedge clk);
        s16.start = 1'b1; s16.a = 16'd100; s16.b = 16'd200;
        @(posedge clk);
        @(negedge clk);
        s16.start = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset", {s16.out[29:0], s16.busy, s16.done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - base), 32'd0);
        run_op(16'd6, 16'd7, 32'd42);

        // Back-to-back with start held high.
        @(negedge clk);
        s16.start = 1'b1; s16.a = 16'd10; s16.b = 16'd10;
        cyc = 0; ndone = 0; t1 = 0;
        while (ndone < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (s16.done) begin
                ndone++;
                if (ndone == 1) begin
                    t1 = cyc;
                    check("b2b_first", s16.out, 32'd100);
                    s16.a = 16'h8000; s16.b = 16'd2;
                end else begin
                    check("b2b_spacing", 32'(cyc - t1), 32'd18);
                    check("b2b_second", s16.out, 32'h00010000);
                    s16.start = 1'b0;
                end
            end
        end
        check("b2b_two_dones", 32'(ndone), 32'd2);
        s16.start = 1'b0;
        repeat (2) @(negedge clk);
        check("b2b_idle", 32'(s16.busy), 32'd0);

        // WIDTH=4 instance.
        @(negedge clk);
        s4.start = 1'b1; s4.a = 4'd15; s4.b = 4'd15;
        @(posedge clk);
        @(negedge clk);
        s4.start = 1'b0;
        check("w4_busy", 32'(s4.busy), 32'd1);
        n4 = 0;
        while (!s4.done && n4 < 20) begin @(negedge clk); n4++; end
        check("w4_latency", 32'(n4), 32'd4);
        check("w4_product", 32'(s4.out), 32'hE1);
        @(negedge clk);
        check("w4_done_one_cycle", {30'd0, s4.busy, s4.done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
